// File: rtl/mpeg_fifo_pkg.sv
// rtl/mpeg_fifo_pkg.sv - shared constants and helpers for the MPEG stream FIFO
package mpeg_fifo_pkg;

    localparam int FIFO_DEPTH_LOG2 = 4;
    localparam int FIFO_PTR_W      = FIFO_DEPTH_LOG2 + 1;
    localparam int MAX_WIDTH       = 512;
    localparam int MAX_PTR_W       = 32;

    function automatic int ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    // Byte 0 swaps with byte nbytes-1; bits above nbytes*8 come back as zero.
    function automatic logic [MAX_WIDTH-1:0] reverse_bytes_width(
        input logic [MAX_WIDTH-1:0] i_word,
        input int                   nbytes
    );
        logic [MAX_WIDTH-1:0] r_out;
        r_out = '0;
        for (int b = 0; b < MAX_WIDTH / 8; b++) begin
            if (b < nbytes) begin
                r_out[8*b +: 8] = i_word[8*(nbytes-1-b) +: 8];
            end
        end
        return r_out;
    endfunction

endpackage

// File: rtl/b2g_converter.sv
// rtl/b2g_converter.sv - combinational binary to Gray conversion
module b2g_converter
    import mpeg_fifo_pkg::*;
#(
    parameter int W = FIFO_PTR_W
) (
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_gray
);

    logic [MAX_PTR_W-1:0] w_gray_wide;

    assign w_gray_wide = bin2gray(MAX_PTR_W'(i_bin));
    assign o_gray      = w_gray_wide[W-1:0];

endmodule

// File: rtl/gray_ptr.sv
// rtl/gray_ptr.sv - binary pointer with its Gray image registered on the same edge
module gray_ptr
    import mpeg_fifo_pkg::*;
#(
    parameter int W = FIFO_PTR_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_bin,
    output logic [W-1:0] o_gray
);

    logic [W-1:0] r_bin;
    logic [W-1:0] r_gray;
    logic [W-1:0] w_bin_next;
    logic [W-1:0] w_gray_next;

    always_comb begin
        w_bin_next = r_bin;
        if (i_clr) begin
            w_bin_next = '0;
        end else if (i_inc) begin
            w_bin_next = r_bin + W'(1);
        end
    end

    // Gray is derived from the next binary value so both registers agree after every edge.
    b2g_converter #(.W(W)) u_b2g (
        .i_bin  (w_bin_next),
        .o_gray (w_gray_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
        end
    end

    assign o_bin  = r_bin;
    assign o_gray = r_gray;

endmodule

// File: rtl/gray_sync_fifo.sv
// rtl/gray_sync_fifo.sv - single-clock Gray-pointer FIFO with optional read-side byte reversal
module gray_sync_fifo
    import mpeg_fifo_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_LOG2  = FIFO_DEPTH_LOG2,
    parameter bit SWAP_ENDIAN = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   wr_ptr_gray,
    output logic [DEPTH_LOG2:0]   rd_ptr_gray,
    output logic                  overflow
);

    localparam int PW    = ptr_width(DEPTH_LOG2);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = (DEPTH_LOG2 == 0) ? 1 : DEPTH_LOG2;

    // Full when the two top Gray bits differ and the rest match; a 1-bit pointer just differs.
    localparam logic [PW-1:0] FULL_XOR = (PW == 1) ? PW'(1) : (PW'(3) << (PW - 2));

    logic [PW-1:0]    w_wr_bin;
    logic [PW-1:0]    w_wr_gray;
    logic [PW-1:0]    w_rd_bin;
    logic [PW-1:0]    w_rd_gray;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [WIDTH-1:0] w_head;
    logic             r_overflow;

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign w_empty   = (w_wr_gray == w_rd_gray);
    assign w_full    = ((w_wr_gray ^ w_rd_gray) == FULL_XOR);
    assign w_wr_fire = wr_valid && !w_full && !flush;
    assign w_rd_fire = rd_ready && !w_empty && !flush;

    gray_ptr #(.W(PW)) u_wr_ptr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (flush),
        .i_inc   (w_wr_fire),
        .o_bin   (w_wr_bin),
        .o_gray  (w_wr_gray)
    );

    gray_ptr #(.W(PW)) u_rd_ptr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (flush),
        .i_inc   (w_rd_fire),
        .o_bin   (w_rd_bin),
        .o_gray  (w_rd_gray)
    );

    generate
        if (DEPTH_LOG2 > 0) begin : g_addr
            assign w_wr_addr = w_wr_bin[AW-1:0];
            assign w_rd_addr = w_rd_bin[AW-1:0];
        end else begin : g_addr_single
            assign w_wr_addr = 1'b0;
            assign w_rd_addr = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_wr_addr] <= wr_data;
        end
    end

    // Sticky until reset; flush deliberately leaves it alone so the host can still see the loss.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (wr_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_head = r_mem[w_rd_addr];

    generate
        if (SWAP_ENDIAN) begin : g_swap
            logic [MAX_WIDTH-1:0] w_swapped;
            assign w_swapped = reverse_bytes_width(MAX_WIDTH'(w_head), WIDTH / 8);
            assign rd_data   = w_swapped[WIDTH-1:0];
        end else begin : g_straight
            assign rd_data = w_head;
        end
    endgenerate

    assign wr_ready    = !w_full;
    assign rd_valid    = !w_empty;
    assign level       = w_wr_bin - w_rd_bin;
    assign wr_ptr_gray = w_wr_gray;
    assign rd_ptr_gray = w_rd_gray;
    assign overflow    = r_overflow;

endmodule
